inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 101 ++++++++++
 tb/tb_inst_queue.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a circular buffer of {pc, inst}
// with first-word-fall-through head decode, flush and synchronous reset.
module inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst,
    output logic                     in_ready,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [3:0]               opcode,
    output logic [3:0]               rd,
    output logic [3:0]               rs1,
    output logic [3:0]               rs2,
    output logic [31:0]              imm,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_mem_r   [DEPTH];
    logic [31:0]   inst_mem_r [DEPTH];
    logic [PW-1:0] rptr_r;
    logic [PW-1:0] wptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   head_pc_s;
    logic [31:0]   head_inst_s;

    assign in_ready  = (count_r < CW'(DEPTH));
    assign out_valid = (count_r != {CW{1'b0}});
    assign count     = count_r;

    // Handshake qualification; flush suppresses both sides for the cycle.
    always_comb begin
        push_s = in_valid && in_ready && !flush;
        pop_s  = out_valid && !stall && !flush;
    end

    // Occupancy next-state: a simultaneous push and pop leaves count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and count state; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rptr_r  <= {PW{1'b0}};
            wptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_nxt_s;
            if (push_s) begin
                wptr_r <= wptr_r + PW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PW'(1);
            end
        end
    end

    // Entry storage; contents are left stale on reset/flush, only pointers matter.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            pc_mem_r[wptr_r]   <= in_pc;
            inst_mem_r[wptr_r] <= in_inst;
        end
    end

    // Head fields are forced to zero while the queue is empty.
    always_comb begin
        if (out_valid) begin
            head_pc_s   = pc_mem_r[rptr_r];
            head_inst_s = inst_mem_r[rptr_r];
        end else begin
            head_pc_s   = 32'd0;
            head_inst_s = 32'd0;
        end
    end

    assign out_pc = head_pc_s;
    assign opcode = head_inst_s[31:28];
    assign rd     = head_inst_s[27:24];
    assign rs1    = head_inst_s[23:20];
    assign rs2    = head_inst_s[19:16];
    assign imm    = {{16{head_inst_s[15]}}, head_inst_s[15:0]};

endmodule

// File: tb/tb_inst_queue.sv
// Directed, table-driven bench for inst_queue (DEPTH = 4) with a few
// hand-written multi-cycle sequences for handshake corner cases.
module tb_inst_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    inst_queue #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
        .in_inst(in_inst), .in_ready(in_ready), .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_pc(out_pc), .opcode(opcode), .rd(rd),
        .rs1(rs1), .rs2(rs2), .imm(imm), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          iv;
        logic [31:0] ipc;
        logic [31:0] iinst;
        bit          st;
        bit          fl;
        int          e_cnt;
        bit          e_rdy;
        bit          e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vq[$];

    localparam logic [31:0] I0 = 32'h1234_8001;
    localparam logic [31:0] I1 = 32'h0000_7FFF;
    localparam logic [31:0] I2 = 32'h5678_0010;
    localparam logic [31:0] I3 = 32'hA9CB_FFFF;
    localparam logic [31:0] S5 = 32'h5ABC_9234;

    function automatic logic [31:0] pinst(input logic [31:0] pc);
        return 32'h7000_0000 | pc;
    endfunction

    task automatic add(input bit r, input bit iv, input logic [31:0] pc,
                       input logic [31:0] inst, input bit st, input bit fl,
                       input int cnt, input bit rdy, input bit vld,
                       input logic [31:0] epc, input logic [31:0] einst);
        vec_t v;
        v.rst = r; v.iv = iv; v.ipc = pc; v.iinst = inst; v.st = st; v.fl = fl;
        v.e_cnt = cnt; v.e_rdy = rdy; v.e_vld = vld; v.e_pc = epc; v.e_inst = einst;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit iv, input logic [31:0] pc,
                         input logic [31:0] inst, input bit st, input bit fl);
        reset = r; in_valid = iv; in_pc = pc; in_inst = inst; stall = st; flush = fl;
    endtask

    task automatic check_all(input int idx, input int cnt, input bit rdy, input bit vld,
                             input logic [31:0] epc, input logic [31:0] einst);
        logic [31:0] eimm;
        eimm = 32'($signed(einst[15:0]));
        chk("count",     idx, 32'(count),     32'(cnt));
        chk("in_ready",  idx, 32'(in_ready),  32'(rdy));
        chk("out_valid", idx, 32'(out_valid), 32'(vld));
        chk("out_pc",    idx, out_pc,         epc);
        chk("opcode",    idx, 32'(opcode),    32'(einst[31:28]));
        chk("rd",        idx, 32'(rd),        32'(einst[27:24]));
        chk("rs1",       idx, 32'(rs1),       32'(einst[23:20]));
        chk("rs2",       idx, 32'(rs2),       32'(einst[19:16]));
        chk("imm",       idx, imm,            eimm);
    endtask

    initial begin
        // reset state
        add(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h0, 32'h0);
        // fill while stalled; head decode visible one cycle after the first push
        add(1'b0, 1'b1, 32'h00, I0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h0, I0);
        add(1'b0, 1'b1, 32'h04, I1, 1'b1, 1'b0, 2, 1'b1, 1'b1, 32'h0, I0);
        add(1'b0, 1'b1, 32'h08, I2, 1'b1, 1'b0, 3, 1'b1, 1'b1, 32'h0, I0);
        add(1'b0, 1'b1, 32'h0C, I3, 1'b1, 1'b0, 4, 1'b0, 1'b1, 32'h0, I0);
        add(1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 1'b1, 1'b0, 4, 1'b0, 1'b1, 32'h0, I0);
        // full with pop: the offered push must not be accepted
        add(1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 1'b0, 1'b0, 3, 1'b1, 1'b1, 32'h04, I1);
        add(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 32'h08, I2);
        add(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h0C, I3);
        add(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h0, 32'h0);
        // steady push+pop at count 2, pointers wrap several times
        add(1'b0, 1'b1, 32'h100, pinst(32'h100), 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h100, pinst(32'h100));
        add(1'b0, 1'b1, 32'h104, pinst(32'h104), 1'b1, 1'b0, 2, 1'b1, 1'b1, 32'h100, pinst(32'h100));
        for (int k = 0; k < 10; k++) begin
            add(1'b0, 1'b1, 32'h108 + 32'(4 * k), pinst(32'h108 + 32'(4 * k)), 1'b0, 1'b0,
                2, 1'b1, 1'b1, 32'h104 + 32'(4 * k), pinst(32'h104 + 32'(4 * k)));
        end
        add(1'b0, 1'b1, 32'h130, pinst(32'h130), 1'b1, 1'b0, 3, 1'b1, 1'b1, 32'h128, pinst(32'h128));
        // flush with same-cycle push and pop
        add(1'b0, 1'b1, 32'h134, pinst(32'h134), 1'b0, 1'b1, 0, 1'b1, 1'b0, 32'h0, 32'h0);
        add(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h0, 32'h0);
        // stall hold on an opcode-5 head
        add(1'b0, 1'b1, 32'h200, S5, 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h200, S5);
        for (int k = 0; k < 5; k++) begin
            add(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h200, S5);
        end
        // reset mid-run at count 3 with a push offered
        add(1'b0, 1'b1, 32'h204, pinst(32'h204), 1'b1, 1'b0, 2, 1'b1, 1'b1, 32'h200, S5);
        add(1'b0, 1'b1, 32'h208, pinst(32'h208), 1'b1, 1'b0, 3, 1'b1, 1'b1, 32'h200, S5);
        add(1'b1, 1'b1, 32'h20C, pinst(32'h20C), 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h0, 32'h0);
        add(1'b0, 1'b1, 32'h300, I0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h300, I0);
        add(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h0, 32'h0);

        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].iv, vq[i].ipc, vq[i].iinst, vq[i].st, vq[i].fl);
            @(posedge clk);
            #1;
            check_all(i, vq[i].e_cnt, vq[i].e_rdy, vq[i].e_vld, vq[i].e_pc, vq[i].e_inst);
        end

        // no bypass: a push into an empty queue is not visible in the same cycle
        drive(1'b0, 1'b1, 32'h400, I1, 1'b0, 1'b0);
        #2;
        chk("nobypass_valid", 100, 32'(out_valid), 32'd0);
        chk("nobypass_pc",    100, out_pc,         32'd0);
        @(posedge clk);
        #1;
        check_all(101, 1, 1'b1, 1'b1, 32'h400, I1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all(102, 0, 1'b1, 1'b0, 32'h0, 32'h0);

        // reset together with flush and push leaves the queue empty
        drive(1'b0, 1'b1, 32'h500, I2, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_all(103, 1, 1'b1, 1'b1, 32'h500, I2);
        drive(1'b1, 1'b1, 32'h504, I3, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_all(104, 0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all(105, 0, 1'b1, 1'b0, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
